branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 164 ++++++++++++++++
 tb/tb_branch_resolve.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   Resolves one branch/jump request at a time. A request is captured when
//   in_valid and in_ready are both high at a rising edge, resolved in the
//   following cycle, and the decision is published with a one-cycle
//   out_valid pulse. A taken result also raises flush for FLUSH_CYCLES
//   consecutive cycles, starting with the out_valid cycle.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   request fields valid this cycle
//   in_ready    out  block can accept a request (IDLE only)
//   op          in   00 BEQZ, 01 BNEZ, 10 J, 11 JR
//   cond        in   condition word (set-compare result, all bits tested)
//   pc_plus4    in   address of the instruction after the branch
//   imm         in   sign-extended byte offset
//   reg_target  in   register target for JR
//   out_valid   out  one-cycle pulse per resolved request
//   taken       out  branch decision, held until the next out_valid
//   target      out  redirect address, held until the next out_valid
//   flush       out  squash request for younger pipeline stages
// ---------------------------------------------------------------------------
module branch_resolve #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] cond,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] reg_target,
  output logic             out_valid,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  output logic             flush
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0] OP_BEQZ = 2'b00;
  localparam logic [1:0] OP_BNEZ = 2'b01;
  localparam logic [1:0] OP_J    = 2'b10;
  localparam logic [1:0] OP_JR   = 2'b11;

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_cond;
  logic [WIDTH-1:0] r_pc_plus4;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_reg_target;
  logic [3:0]       r_cnt;
  logic             r_out_valid;
  logic             r_taken;
  logic [WIDTH-1:0] r_target;
  logic             r_flush;

  logic             w_zero;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;

  // Decision and redirect address from the captured request.
  always_comb begin
    w_zero   = (r_cond == {WIDTH{1'b0}});
    w_taken  = 1'b0;
    w_target = r_pc_plus4 + r_imm;
    case (r_op)
      OP_BEQZ: w_taken = w_zero;
      OP_BNEZ: w_taken = ~w_zero;
      OP_J:    w_taken = 1'b1;
      OP_JR: begin
        w_taken  = 1'b1;
        w_target = r_reg_target;
      end
      default: w_taken = 1'b0;
    endcase
  end

  // FSM, request capture and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_op         <= 2'b00;
      r_cond       <= {WIDTH{1'b0}};
      r_pc_plus4   <= {WIDTH{1'b0}};
      r_imm        <= {WIDTH{1'b0}};
      r_reg_target <= {WIDTH{1'b0}};
      r_cnt        <= 4'd0;
      r_out_valid  <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= {WIDTH{1'b0}};
      r_flush      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      // The flush counter winds down on its own: the FSM hands back to
      // IDLE one cycle before the last flush cycle, so the final flush
      // cycle overlaps the first cycle in which a new request is accepted.
      if (r_cnt != 4'd0) begin
        r_cnt   <= r_cnt - 4'd1;
        r_flush <= (r_cnt > 4'd1);
      end else begin
        r_flush <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op         <= op;
            r_cond       <= cond;
            r_pc_plus4   <= pc_plus4;
            r_imm        <= imm;
            r_reg_target <= reg_target;
            r_state      <= RESOLVE;
          end else begin
            r_state <= IDLE;
          end
        end
        RESOLVE: begin
          r_out_valid <= 1'b1;
          r_taken     <= w_taken;
          r_target    <= w_target;
          if (w_taken && (FC != 4'd0)) begin
            r_cnt   <= FC;
            r_flush <= 1'b1;
            r_state <= FLUSH;
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          // Counter value 2 means only one flush cycle remains after this one.
          if (r_cnt <= 4'd2) begin
            r_state <= IDLE;
          end else begin
            r_state <= FLUSH;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign taken     = r_taken;
  assign target    = r_target;
  assign flush     = r_flush;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] cond, pc_plus4, imm, reg_target;
  logic        out_valid, taken, flush;
  logic [31:0] target;

  // second instance with FLUSH_CYCLES = 0
  logic        z_in_valid, z_in_ready, z_out_valid, z_taken, z_flush;
  logic [1:0]  z_op;
  logic [31:0] z_cond, z_pc_plus4, z_imm, z_reg_target, z_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve #(.WIDTH(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .pc_plus4(pc_plus4), .imm(imm),
    .reg_target(reg_target), .out_valid(out_valid), .taken(taken),
    .target(target), .flush(flush)
  );

  branch_resolve #(.WIDTH(32), .FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .op(z_op), .cond(z_cond), .pc_plus4(z_pc_plus4), .imm(z_imm),
    .reg_target(z_reg_target), .out_valid(z_out_valid), .taken(z_taken),
    .target(z_target), .flush(z_flush)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] cond;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rt;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // One complete request on the FLUSH_CYCLES=2 instance, checked cycle by cycle.
  task automatic run_req(input vec_t v, input string tag);
    wait_ready(tag);
    op = v.op; cond = v.cond; pc_plus4 = v.pc4; imm = v.imm; reg_target = v.rt;
    in_valid = 1'b1;
    step();                                   // accept edge
    in_valid = 1'b0;
    chk({tag, ".c1_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".c1_in_ready"},  32'(in_ready),  32'd0);
    step();                                   // result cycle
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".taken"},     32'(taken),     32'(v.exp_taken));
    chk({tag, ".target"},    target,         v.exp_target);
    chk({tag, ".flush"},     32'(flush),     32'(v.exp_taken));
    chk({tag, ".c2_in_ready"}, 32'(in_ready), 32'(!v.exp_taken));
    step();
    chk({tag, ".c3_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".c3_flush"},     32'(flush),     32'(v.exp_taken));
    chk({tag, ".c3_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".hold_target"},  target,         v.exp_target);
    chk({tag, ".hold_taken"},   32'(taken),     32'(v.exp_taken));
    if (v.exp_taken) begin
      step();
      chk({tag, ".c4_flush"}, 32'(flush), 32'd0);
    end
  endtask

  // continuous-request sequence bookkeeping
  logic [31:0] q_target[$];
  logic        q_taken[$];
  int          acc_cyc[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, outs, idx, cyc;
    logic pend;
    logic [31:0] et;
    logic ek;

    vecs[0] = '{2'b00, 32'h0000_0000, 32'h0000_0100, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0120};
    vecs[1] = '{2'b01, 32'h0000_0001, 32'h0000_0200, 32'h0000_0010, 32'h0, 1'b1, 32'h0000_0210};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h0000_0300, 32'h0000_0008, 32'h0, 1'b0, 32'h0000_0308};
    vecs[3] = '{2'b11, 32'h0000_0000, 32'h0000_0400, 32'h0000_0004, 32'hDEAD_BEE0, 1'b1, 32'hDEAD_BEE0};
    vecs[4] = '{2'b10, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 1'b1, 32'h0000_0004};
    vecs[5] = '{2'b01, 32'h0000_0000, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0, 1'b0, 32'h0000_0FF0};
    vecs[6] = '{2'b00, 32'h0000_0002, 32'h0000_0500, 32'h0000_0004, 32'h0, 1'b0, 32'h0000_0504};
    vecs[7] = '{2'b01, 32'h8000_0000, 32'h0000_0600, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0000_05FC};

    rst = 1'b1; in_valid = 1'b0; op = 2'b00; cond = 32'h0; pc_plus4 = 32'h0;
    imm = 32'h0; reg_target = 32'h0;
    z_in_valid = 1'b0; z_op = 2'b00; z_cond = 32'h0; z_pc_plus4 = 32'h0;
    z_imm = 32'h0; z_reg_target = 32'h0;

    step(); step();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.taken",     32'(taken),     32'd0);
    chk("rst.target",    target,         32'h0);
    chk("rst.flush",     32'(flush),     32'd0);
    rst = 1'b0;
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // table-driven vectors
    for (int i = 0; i < 8; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // in_valid held high, alternating taken (even) / untaken (odd) BEQZ
    acc = 0; outs = 0; idx = 0; pend = 1'b0; cyc = 0;
    op = 2'b00; cond = 32'h0; pc_plus4 = 32'h1000; imm = 32'h4;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (q_taken.size() == 0) begin
          chk("cont.spurious_out", 32'd1, 32'd0);
        end else begin
          ek = q_taken.pop_front();
          et = q_target.pop_front();
          chk($sformatf("cont.taken%0d", outs), 32'(taken), 32'(ek));
          chk($sformatf("cont.target%0d", outs), target, et);
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[acc] = c;
        q_taken.push_back(idx % 2 == 0);
        q_target.push_back(32'h1000 + 32'(idx) * 32'h10 + 32'h4);
        acc++;
        pend = 1'b1;
      end
      step();
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 6) begin
          cond = (idx % 2 == 0) ? 32'h0 : 32'h1;
          pc_plus4 = 32'h1000 + 32'(idx) * 32'h10;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("cont.accepts", 32'(acc), 32'd6);
    chk("cont.outs",    32'(outs), 32'd6);
    for (int k = 1; k < 6; k++)
      chk($sformatf("cont.spacing%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]),
          ((k - 1) % 2 == 0) ? 32'd3 : 32'd2);

    // reset during the first flush cycle
    wait_ready("rstf");
    op = 2'b10; pc_plus4 = 32'h0000_0700; imm = 32'h0000_0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rstf.pre_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstf.flush",     32'(flush),     32'd0);
    chk("rstf.out_valid", 32'(out_valid), 32'd0);
    chk("rstf.target",    target,         32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("rstf.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("rstf.no_pulse", 32'(out_valid), 32'd0);
    run_req('{2'b01, 32'h0000_0005, 32'h0000_0040, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0080}, "after_rst");

    // FLUSH_CYCLES = 0 instance, taken J
    z_op = 2'b10; z_pc_plus4 = 32'h0000_0010; z_imm = 32'h0000_0010;
    chk("z.ready0", 32'(z_in_ready), 32'd1);
    z_in_valid = 1'b1;
    step();
    z_in_valid = 1'b0;
    chk("z.c1_out_valid", 32'(z_out_valid), 32'd0);
    chk("z.c1_flush",     32'(z_flush),     32'd0);
    step();
    chk("z.out_valid", 32'(z_out_valid), 32'd1);
    chk("z.taken",     32'(z_taken),     32'd1);
    chk("z.target",    z_target,         32'h0000_0020);
    chk("z.flush",     32'(z_flush),     32'd0);
    step();
    chk("z.c3_in_ready",  32'(z_in_ready),  32'd1);
    chk("z.c3_flush",     32'(z_flush),     32'd0);
    chk("z.c3_out_valid", 32'(z_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
